// File: rtl/qspi_flash_target_if.sv
// Pin bundle between the quad-SPI initiator, the flash responder and its backing byte memory.
// The slave modport is the responder's view; the master modport is the initiator/memory side.
interface qspi_flash_target_if;
    logic        ss;
    logic        sck_en;
    logic [3:0]  io_in;
    logic [3:0]  io_out;
    logic        io_oe;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic [7:0]  mem_data;
    logic        xip_active;

    modport slave (
        input  ss, sck_en, io_in, mem_data,
        output io_out, io_oe, mem_rd, mem_addr, xip_active
    );

    modport master (
        output ss, sck_en, io_in, mem_data,
        input  io_out, io_oe, mem_rd, mem_addr, xip_active
    );
endinterface

// File: rtl/qspi_flash_target.sv
// Quad-SPI flash responder for Fast Read Quad I/O (EBh), serving bytes from a 1-cycle-latency memory port.
// Define QSPI_TGT_XIP_EN to let the mode byte latch continuous-read (XIP) mode.
module qspi_flash_target (
    input  logic                  spiclk,
    input  logic                  reset_n,
    qspi_flash_target_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_MODE   = 3'd3,
        ST_DUMMY  = 3'd4,
        ST_DATA   = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    state_t      state_r,    state_nx_s;
    logic [2:0]  cnt_r,      cnt_nx_s;
    logic [23:0] sh_r,       sh_nx_s;
    logic        xip_r,      xip_nx_s;
    logic [3:0]  lo_r,       lo_nx_s;
    logic        hi_phase_r, hi_phase_nx_s;
    logic [3:0]  io_out_r,   io_out_nx_s;
    logic        io_oe_r,    io_oe_nx_s;
    logic        mem_rd_r,   mem_rd_nx_s;
    logic [23:0] mem_addr_r, mem_addr_nx_s;
    logic [7:0]  byte_r;
    logic        rd_d_r;

    logic        spi_clk_s;
    logic [7:0]  cur_byte_s;
    logic [7:0]  cmd_byte_s;
    logic [23:0] addr_full_s;

    assign spi_clk_s   = bus.ss & bus.sck_en;
    // Read data is used straight off the port in its valid cycle, otherwise from the capture register.
    assign cur_byte_s  = rd_d_r ? bus.mem_data : byte_r;
    assign cmd_byte_s  = {sh_r[6:0], bus.io_in[0]};
    assign addr_full_s = {sh_r[19:0], bus.io_in};

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        sh_nx_s       = sh_r;
        xip_nx_s      = xip_r;
        lo_nx_s       = lo_r;
        hi_phase_nx_s = hi_phase_r;
        io_out_nx_s   = io_out_r;
        io_oe_nx_s    = io_oe_r;
        mem_rd_nx_s   = 1'b0;
        mem_addr_nx_s = mem_addr_r;

        if (!bus.ss) begin
            state_nx_s    = ST_IDLE;
            cnt_nx_s      = 3'd0;
            sh_nx_s       = 24'd0;
            hi_phase_nx_s = 1'b0;
            io_out_nx_s   = 4'd0;
            io_oe_nx_s    = 1'b0;
        end else if (spi_clk_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (xip_r) begin
                        state_nx_s = ST_ADDR;
                        sh_nx_s    = {20'd0, bus.io_in};
                        cnt_nx_s   = 3'd1;
                    end else begin
                        state_nx_s = ST_CMD;
                        sh_nx_s    = {23'd0, bus.io_in[0]};
                        cnt_nx_s   = 3'd1;
                    end
                end
                ST_CMD: begin
                    if (cnt_r == 3'd7) begin
                        cnt_nx_s = 3'd0;
                        if (cmd_byte_s == 8'hEB) begin
                            state_nx_s = ST_ADDR;
                        end else begin
                            state_nx_s = ST_IGNORE;
                        end
                    end else begin
                        cnt_nx_s = cnt_r + 3'd1;
                        sh_nx_s  = {sh_r[22:0], bus.io_in[0]};
                    end
                end
                ST_ADDR: begin
                    sh_nx_s = addr_full_s;
                    if (cnt_r == 3'd5) begin
                        mem_rd_nx_s   = 1'b1;
                        mem_addr_nx_s = addr_full_s;
                        state_nx_s    = ST_MODE;
                        cnt_nx_s      = 3'd0;
                    end else begin
                        cnt_nx_s = cnt_r + 3'd1;
                    end
                end
                ST_MODE: begin
                    // First mode nibble lands in sh_r[3:0], so M[5:4] is sh_r[1:0] on the second clock.
                    sh_nx_s = addr_full_s;
                    if (cnt_r == 3'd0) begin
                        cnt_nx_s = 3'd1;
                    end else begin
`ifdef QSPI_TGT_XIP_EN
                        xip_nx_s = (sh_r[1:0] == 2'b10);
`else
                        xip_nx_s = 1'b0;
`endif
                        state_nx_s = ST_DUMMY;
                        cnt_nx_s   = 3'd0;
                    end
                end
                ST_DUMMY: begin
                    if (cnt_r == 3'd3) begin
                        io_out_nx_s   = cur_byte_s[7:4];
                        lo_nx_s       = cur_byte_s[3:0];
                        io_oe_nx_s    = 1'b1;
                        hi_phase_nx_s = 1'b1;
                        mem_rd_nx_s   = 1'b1;
                        mem_addr_nx_s = mem_addr_r + 24'd1;
                        state_nx_s    = ST_DATA;
                        cnt_nx_s      = 3'd0;
                    end else begin
                        cnt_nx_s = cnt_r + 3'd1;
                    end
                end
                ST_DATA: begin
                    // Placing a high nibble also prefetches the following byte, two SPI clocks ahead of use.
                    if (hi_phase_r) begin
                        io_out_nx_s   = lo_r;
                        hi_phase_nx_s = 1'b0;
                    end else begin
                        io_out_nx_s   = cur_byte_s[7:4];
                        lo_nx_s       = cur_byte_s[3:0];
                        hi_phase_nx_s = 1'b1;
                        mem_rd_nx_s   = 1'b1;
                        mem_addr_nx_s = mem_addr_r + 24'd1;
                    end
                end
                ST_IGNORE: begin
                    io_oe_nx_s = 1'b0;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = 3'd0;
                    io_oe_nx_s = 1'b0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge spiclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 3'd0;
            sh_r       <= 24'd0;
            xip_r      <= 1'b0;
            lo_r       <= 4'd0;
            hi_phase_r <= 1'b0;
            io_out_r   <= 4'd0;
            io_oe_r    <= 1'b0;
            mem_rd_r   <= 1'b0;
            mem_addr_r <= 24'd0;
            byte_r     <= 8'd0;
            rd_d_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            sh_r       <= sh_nx_s;
            xip_r      <= xip_nx_s;
            lo_r       <= lo_nx_s;
            hi_phase_r <= hi_phase_nx_s;
            io_out_r   <= io_out_nx_s;
            io_oe_r    <= io_oe_nx_s;
            mem_rd_r   <= mem_rd_nx_s;
            mem_addr_r <= mem_addr_nx_s;
            byte_r     <= cur_byte_s;
            rd_d_r     <= mem_rd_r;
        end
    end

    assign bus.io_out     = io_out_r;
    assign bus.io_oe      = io_oe_r;
    assign bus.mem_rd     = mem_rd_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.xip_active = xip_r;

endmodule

// File: tb/tb_qspi_flash_target.sv
// Randomised bench for qspi_flash_target: drives QSPI transactions, models the byte memory,
// and predicts every SPI-clock output from the command/address/mode/dummy/data framing.
module tb_qspi_flash_target;

    logic spiclk = 1'b0;
    logic reset_n;

    qspi_flash_target_if bus ();

    qspi_flash_target dut (
        .spiclk  (spiclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 spiclk = ~spiclk;

`ifdef QSPI_TGT_XIP_EN
    localparam bit XIP_EN = 1'b1;
`else
    localparam bit XIP_EN = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem_a [int];
    logic [23:0] rdq [$];
    bit          xip_m = 1'b0;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (mem_a.exists(int'(a))) return mem_a[int'(a)];
        else return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // Byte memory: data valid the cycle after a strobe, garbage otherwise.
    always @(posedge spiclk) begin
        if (bus.mem_rd === 1'b1) begin
            rdq.push_back(bus.mem_addr);
            bus.mem_data <= mem_byte(bus.mem_addr);
        end else begin
            bus.mem_data <= 8'($urandom);
        end
    end

    // One transaction: optional command, address, mode, dummy, data clocks; checks every SPI clock.
    task automatic run_txn(input bit with_cmd, input logic [7:0] cmd, input logic [23:0] addr,
                           input logic [7:0] mode, input int nbytes, input int stop_at,
                           input bit use_rst, input bit gaps, input string tag);
        logic [3:0]  nibs [$];
        logic [7:0]  cmdv;
        logic [23:0] a_m;
        logic [7:0]  b;
        logic [3:0]  en;
        logic [3:0]  so;
        logic        soe;
        int          total;
        int          base;
        int          ds;
        int          j;
        bit          ok;
        if (with_cmd) for (int i = 0; i < 8; i++) nibs.push_back({3'($urandom), cmd[7-i]});
        for (int i = 0; i < 6; i++) nibs.push_back(addr[23-4*i -: 4]);
        nibs.push_back(mode[7:4]);
        nibs.push_back(mode[3:0]);
        for (int i = 0; i < 4 + 2*nbytes; i++) nibs.push_back(4'($urandom));
        total = nibs.size();
        if (stop_at >= 0 && stop_at < total) total = stop_at;
        // What the target should make of the nibble stream.
        if (xip_m) begin
            ok = 1'b1; base = 0;
        end else begin
            cmdv = 8'd0;
            for (int i = 0; i < 8; i++) cmdv = {cmdv[6:0], nibs[i][0]};
            ok = (cmdv == 8'hEB); base = 8;
        end
        a_m = 24'd0;
        for (int i = 0; i < 6; i++) if (base + i < nibs.size()) a_m = {a_m[19:0], nibs[base+i]};
        ds = base + 12;
        rdq.delete();
        for (int k = 0; k < total; k++) begin
            if (gaps) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    so = bus.io_out; soe = bus.io_oe;
                    bus.ss = 1'b1; bus.sck_en = 1'b0; bus.io_in = 4'($urandom);
                    @(negedge spiclk);
                    checks++;
                    if (bus.io_out !== so || bus.io_oe !== soe) begin
                        errors++;
                        $display("FAIL %s hold k=%0d: io_out=%h io_oe=%b, required %h %b", tag, k, bus.io_out, bus.io_oe, so, soe);
                    end
                end
            end
            if (ok && k >= ds) begin
                j  = k - ds;
                b  = mem_byte(a_m + 24'(j / 2));
                en = (j % 2 == 0) ? b[7:4] : b[3:0];
                checks++;
                if (bus.io_oe !== 1'b1 || bus.io_out !== en) begin
                    errors++;
                    $display("FAIL %s data k=%0d: io_oe=%b io_out=%h, required 1 %h", tag, k, bus.io_oe, bus.io_out, en);
                end
            end else begin
                checks++;
                if (bus.io_oe !== 1'b0) begin
                    errors++;
                    $display("FAIL %s oe_low k=%0d: io_oe=%b, required 0", tag, k, bus.io_oe);
                end
            end
            bus.ss = 1'b1; bus.sck_en = 1'b1; bus.io_in = nibs[k];
            @(negedge spiclk);
        end
        if (use_rst) begin
            reset_n = 1'b0;
            #1;
            checks++;
            if ({bus.io_out, bus.io_oe, bus.mem_rd, bus.mem_addr, bus.xip_active} !== 31'd0) begin
                errors++;
                $display("FAIL %s async_reset: out=%h oe=%b rd=%b addr=%h xip=%b, required all 0", tag,
                         bus.io_out, bus.io_oe, bus.mem_rd, bus.mem_addr, bus.xip_active);
            end
            xip_m = 1'b0;
            bus.ss = 1'b0; bus.sck_en = 1'b0;
            @(negedge spiclk);
            reset_n = 1'b1;
            repeat (2) @(negedge spiclk);
        end else begin
            if (XIP_EN && ok && total >= base + 8) xip_m = (nibs[base+6][1:0] == 2'b10);
            bus.ss = 1'b0; bus.sck_en = 1'b1; bus.io_in = 4'($urandom);
            @(negedge spiclk);
            checks++;
            if (bus.io_oe !== 1'b0 || bus.xip_active !== xip_m) begin
                errors++;
                $display("FAIL %s after_ss: io_oe=%b xip=%b, required 0 %b", tag, bus.io_oe, bus.xip_active, xip_m);
            end
            repeat (2) @(negedge spiclk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.ss = 1'b0; bus.sck_en = 1'b0; bus.io_in = 4'd0;
        repeat (3) @(negedge spiclk);
        checks++; if (bus.io_out !== 4'd0)     begin errors++; $display("FAIL reset io_out: %h, required 0", bus.io_out); end
        checks++; if (bus.io_oe !== 1'b0)      begin errors++; $display("FAIL reset io_oe: %b, required 0", bus.io_oe); end
        checks++; if (bus.mem_rd !== 1'b0)     begin errors++; $display("FAIL reset mem_rd: %b, required 0", bus.mem_rd); end
        checks++; if (bus.mem_addr !== 24'd0)  begin errors++; $display("FAIL reset mem_addr: %h, required 0", bus.mem_addr); end
        checks++; if (bus.xip_active !== 1'b0) begin errors++; $display("FAIL reset xip: %b, required 0", bus.xip_active); end
        reset_n = 1'b1;
        repeat (2) @(negedge spiclk);
    endtask

    task automatic test_basic_read();
        mem_a[32'h100] = 8'h11; mem_a[32'h101] = 8'h22; mem_a[32'h102] = 8'h33; mem_a[32'h103] = 8'h44;
        run_txn(1'b1, 8'hEB, 24'h000100, 8'hFF, 4, -1, 1'b0, 1'b0, "basic");
        checks++;
        if (rdq.size() < 4 || rdq[0] !== 24'h000100 || rdq[3] !== 24'h000103) begin
            errors++;
            $display("FAIL basic reads: n=%0d first=%h, required >=4 from 000100", rdq.size(), (rdq.size() > 0) ? rdq[0] : 24'hx);
        end
        checks++; if (bus.xip_active !== 1'b0) begin errors++; $display("FAIL basic xip: %b, required 0", bus.xip_active); end
    endtask

    task automatic test_xip();
        run_txn(1'b1, 8'hEB, 24'h000100, 8'h20, 4, -1, 1'b0, 1'b1, "xip_enter");
        checks++; if (bus.xip_active !== XIP_EN) begin errors++; $display("FAIL xip_enter: %b, required %b", bus.xip_active, XIP_EN); end
        run_txn(1'b0, 8'h00, 24'h000102, 8'hA5, 2, -1, 1'b0, 1'b0, "xip_nocmd");
        checks++;
        if (XIP_EN ? (rdq.size() < 2 || rdq[0] !== 24'h000102) : (rdq.size() != 0)) begin
            errors++;
            $display("FAIL xip_nocmd reads: n=%0d, required %s", rdq.size(), XIP_EN ? "from 000102" : "none");
        end
        run_txn(!xip_m, 8'hEB, 24'h00ABCD, 8'hFF, 1, -1, 1'b0, 1'b1, "xip_exit");
        checks++; if (bus.xip_active !== 1'b0) begin errors++; $display("FAIL xip_exit: %b, required 0", bus.xip_active); end
    endtask

    task automatic test_bad_cmd();
        run_txn(1'b1, 8'h03, 24'h000100, 8'h00, 3, -1, 1'b0, 1'b1, "cmd03");
        checks++; if (rdq.size() != 0) begin errors++; $display("FAIL cmd03 mem_rd: %0d pulses, required 0", rdq.size()); end
        run_txn(1'b1, 8'hEB, 24'h000101, 8'hFF, 2, -1, 1'b0, 1'b0, "after03");
        checks++; if (rdq.size() < 2 || rdq[0] !== 24'h000101) begin errors++; $display("FAIL after03 reads: n=%0d, required from 000101", rdq.size()); end
    endtask

    task automatic test_wrap();
        logic [23:0] exp_a;
        run_txn(1'b1, 8'hEB, 24'hFFFFFE, 8'hFF, 4, -1, 1'b0, 1'b1, "wrap");
        checks++; if (rdq.size() < 4) begin errors++; $display("FAIL wrap count: %0d, required >=4", rdq.size()); end
        exp_a = 24'hFFFFFE;
        for (int i = 0; i < 4 && i < rdq.size(); i++) begin
            checks++;
            if (rdq[i] !== exp_a) begin errors++; $display("FAIL wrap addr%0d: %h, required %h", i, rdq[i], exp_a); end
            exp_a = exp_a + 24'd1;
        end
    endtask

    task automatic test_abort();
        run_txn(1'b1, 8'hEB, 24'hABC123, 8'hFF, 2, 11, 1'b0, 1'b0, "abort");
        checks++; if (rdq.size() != 0) begin errors++; $display("FAIL abort mem_rd: %0d pulses, required 0", rdq.size()); end
        mem_a[32'h10] = 8'hC3; mem_a[32'h11] = 8'h7E;
        run_txn(1'b1, 8'hEB, 24'h000010, 8'hFF, 2, -1, 1'b0, 1'b1, "post_abort");
        checks++; if (rdq.size() < 1 || rdq[0] !== 24'h000010) begin errors++; $display("FAIL post_abort addr: n=%0d, required 000010", rdq.size()); end
    endtask

    task automatic test_reset_mid();
        run_txn(1'b1, 8'hEB, 24'h000200, 8'h20, 2, -1, 1'b0, 1'b0, "rst_setup");
        run_txn(!xip_m, 8'hEB, 24'h000300, 8'h20, 3, (xip_m ? 12 : 20) + 3, 1'b1, 1'b0, "rst_mid");
        checks++; if (bus.xip_active !== 1'b0) begin errors++; $display("FAIL rst_mid xip: %b, required 0", bus.xip_active); end
        run_txn(1'b0, 8'h00, 24'h000102, 8'hFF, 2, -1, 1'b0, 1'b0, "rst_nocmd");
        checks++; if (rdq.size() != 0) begin errors++; $display("FAIL rst_nocmd mem_rd: %0d pulses, required 0", rdq.size()); end
        run_txn(1'b1, 8'hEB, 24'h000102, 8'hFF, 2, -1, 1'b0, 1'b0, "rst_cmd");
    endtask

    task automatic test_random();
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n;
        bit          acc;
        for (int t = 0; t < 10; t++) begin
            cmd  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hEB;
            addr = 24'($urandom);
            n    = $urandom_range(1, 5);
            acc  = xip_m || (cmd == 8'hEB);
            run_txn(!xip_m, cmd, addr, 8'($urandom), n, -1, 1'b0, 1'b1, "random");
            checks++;
            if (acc ? (rdq.size() < n || rdq[0] !== addr) : (rdq.size() != 0)) begin
                errors++;
                $display("FAIL random reads t=%0d: n=%0d first=%h, required acc=%b addr=%h", t, rdq.size(),
                         (rdq.size() > 0) ? rdq[0] : 24'hx, acc, addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_xip();
        test_bad_cmd();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
